// File: rtl/jesd_sync_monitor_pkg.sv
// Shared definitions for the JESD204 SYNC~/SYSREF monitor: link FSM encoding,
// synchroniser depth and a saturating increment helper.
package jesd_sync_monitor_pkg;

  localparam int SYNC_DEPTH = 2;

  localparam logic [1:0] S_CGS    = 2'd0;
  localparam logic [1:0] S_QUAL   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  // Increments v unless it already holds the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/jesd_sync_link_mon.sv
// One SYNC~ link: 2-flop synchroniser, glitch filter, CGS/QUAL/LOCKED FSM,
// sticky loss flag and saturating loss counter.
module jesd_sync_link_mon
  import jesd_sync_monitor_pkg::*;
#(
  parameter int FILTER_CYCLES = 4,
  parameter int LOCK_CYCLES   = 256,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync_in,
  input  logic                 clear_stats,
  output logic                 link_locked,
  output logic                 link_lost,
  output logic [CNT_WIDTH-1:0] loss_count
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int QW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [SYNC_DEPTH-1:0] sync_ff_q, sync_ff_d;
  logic                  synced;
  logic                  filt_q, filt_d;
  logic [FW-1:0]         filt_cnt_q, filt_cnt_d, filt_cnt_inc;
  logic [1:0]            state_q, state_d;
  logic [QW-1:0]         qual_q, qual_d, qual_inc;
  logic                  locked_q, locked_d;
  logic                  lost_q, lost_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  loss_evt;

  assign synced = sync_ff_q[SYNC_DEPTH-1];

  always_comb begin
    sync_ff_d    = {sync_ff_q[SYNC_DEPTH-2:0], sync_in};
    filt_cnt_inc = filt_cnt_q + 1'b1;
    filt_d       = filt_q;
    filt_cnt_d   = '0;
    if (synced != filt_q) begin
      if (32'(filt_cnt_inc) == 32'(FILTER_CYCLES)) filt_d = synced;
      else filt_cnt_d = filt_cnt_inc;
    end

    // FSM follows the filter's next value so lock lands LOCK_CYCLES after the filtered rise.
    qual_inc = qual_q + 1'b1;
    state_d  = state_q;
    qual_d   = qual_q;
    loss_evt = 1'b0;
    case (state_q)
      S_CGS: begin
        if (filt_d) begin
          qual_d  = '0;
          state_d = (LOCK_CYCLES == 1) ? S_LOCKED : S_QUAL;
        end
      end
      S_QUAL: begin
        if (!filt_d) begin
          state_d = S_CGS;
        end else begin
          qual_d = qual_inc;
          if (32'(qual_inc) == 32'(LOCK_CYCLES - 1)) state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (!filt_d) begin
          state_d  = S_CGS;
          loss_evt = 1'b1;
        end
      end
      default: state_d = S_CGS;
    endcase

    locked_d = (state_q == S_LOCKED);

    lost_d = lost_q;
    cnt_d  = cnt_q;
    if (clear_stats) begin
      lost_d = 1'b0;
      cnt_d  = '0;
    end
    // A loss in the same cycle as a clear survives as a count of one.
    if (loss_evt) begin
      lost_d = 1'b1;
      cnt_d  = clear_stats ? CNT_WIDTH'(1) : CNT_WIDTH'(sat_inc(32'(cnt_q), CNT_WIDTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff_q  <= '0;
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
      state_q    <= S_CGS;
      qual_q     <= '0;
      locked_q   <= 1'b0;
      lost_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_ff_q  <= sync_ff_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      qual_q     <= qual_d;
      locked_q   <= locked_d;
      lost_q     <= lost_d;
      cnt_q      <= cnt_d;
    end
  end

  assign link_locked = locked_q;
  assign link_lost   = lost_q;
  assign loss_count  = cnt_q;

endmodule

// File: rtl/jesd_sync_monitor.sv
// JESD204 SYNC~/SYSREF observer: per-link lock/loss tracking, SYSREF edge count
// and period check, and a single registered interrupt.
module jesd_sync_monitor
  import jesd_sync_monitor_pkg::*;
#(
  parameter int NUM_LINKS     = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int LOCK_CYCLES   = 256,
  parameter int CNT_WIDTH     = 16,
  parameter int PERIOD_WIDTH  = 16
) (
  input  logic                           core_clk,
  input  logic                           core_resetn,
  input  logic [NUM_LINKS-1:0]           sync_in,
  input  logic                           sysref_in,
  input  logic                           clear_stats,
  input  logic [PERIOD_WIDTH-1:0]        expected_period,
  output logic [NUM_LINKS-1:0]           link_locked,
  output logic [NUM_LINKS-1:0]           link_lost,
  output logic [NUM_LINKS*CNT_WIDTH-1:0] loss_count,
  output logic [CNT_WIDTH-1:0]           sysref_count,
  output logic [PERIOD_WIDTH-1:0]        sysref_period,
  output logic                           sysref_err,
  output logic                           irq
);

  for (genvar k = 0; k < NUM_LINKS; k++) begin : g_link
    jesd_sync_link_mon #(
      .FILTER_CYCLES(FILTER_CYCLES),
      .LOCK_CYCLES  (LOCK_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_link (
      .clk        (core_clk),
      .rst_n      (core_resetn),
      .sync_in    (sync_in[k]),
      .clear_stats(clear_stats),
      .link_locked(link_locked[k]),
      .link_lost  (link_lost[k]),
      .loss_count (loss_count[k*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  logic [SYNC_DEPTH-1:0]   sr_ff_q, sr_ff_d;
  logic                    sr_prev_q, sr_prev_d;
  logic                    sr_edge;
  logic [PERIOD_WIDTH-1:0] per_q, per_d, per_inc;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0]    sr_cnt_q, sr_cnt_d;
  logic                    err_q, err_d;
  logic                    armed_q, armed_d;
  logic                    irq_q, irq_d;

  always_comb begin
    sr_ff_d   = {sr_ff_q[SYNC_DEPTH-2:0], sysref_in};
    sr_prev_d = sr_ff_q[SYNC_DEPTH-1];
    sr_edge   = sr_ff_q[SYNC_DEPTH-1] & ~sr_prev_q;

    // per_inc doubles as the measured period: cycles since the last edge, plus one.
    per_inc = PERIOD_WIDTH'(sat_inc(32'(per_q), PERIOD_WIDTH));
    per_d   = sr_edge ? '0 : per_inc;

    sr_cnt_d = sr_cnt_q;
    period_d = period_q;
    err_d    = err_q;
    armed_d  = armed_q;
    if (clear_stats) begin
      sr_cnt_d = '0;
      period_d = '0;
      err_d    = 1'b0;
      armed_d  = 1'b0;
    end
    if (sr_edge) begin
      armed_d  = 1'b1;
      sr_cnt_d = clear_stats ? CNT_WIDTH'(1) : CNT_WIDTH'(sat_inc(32'(sr_cnt_q), CNT_WIDTH));
      if (armed_q && !clear_stats) begin
        period_d = per_inc;
        if ((expected_period != '0) && (per_inc != expected_period)) err_d = 1'b1;
      end
    end

    irq_d = (|link_lost) | err_q;
  end

  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) begin
      sr_ff_q   <= '0;
      sr_prev_q <= 1'b0;
      per_q     <= '0;
      period_q  <= '0;
      sr_cnt_q  <= '0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sr_ff_q   <= sr_ff_d;
      sr_prev_q <= sr_prev_d;
      per_q     <= per_d;
      period_q  <= period_d;
      sr_cnt_q  <= sr_cnt_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
      irq_q     <= irq_d;
    end
  end

  assign sysref_count  = sr_cnt_q;
  assign sysref_period = period_q;
  assign sysref_err    = err_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_jesd_sync_monitor.sv
// Self-checking bench for jesd_sync_monitor with a scenario-level reference model.
module tb_jesd_sync_monitor;

  localparam int NL      = 2;
  localparam int FC      = 4;
  localparam int LC      = 256;
  localparam int CW      = 4;
  localparam int PW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int LOCK_LAT = 2 + FC + LC;

  logic              core_clk = 1'b0;
  logic              core_resetn = 1'b0;
  logic [NL-1:0]     sync_in = '0;
  logic              sysref_in = 1'b0;
  logic              clear_stats = 1'b0;
  logic [PW-1:0]     expected_period = '0;
  logic [NL-1:0]     link_locked;
  logic [NL-1:0]     link_lost;
  logic [NL*CW-1:0]  loss_count;
  logic [CW-1:0]     sysref_count;
  logic [PW-1:0]     sysref_period;
  logic              sysref_err;
  logic              irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int exp_loss [NL];
  bit exp_lost [NL];
  bit exp_lock [NL];
  int sr_cnt;
  int sr_period;
  bit sr_err;
  bit sr_armed;
  int sr_last;

  jesd_sync_monitor #(
    .NUM_LINKS    (NL),
    .FILTER_CYCLES(FC),
    .LOCK_CYCLES  (LC),
    .CNT_WIDTH    (CW),
    .PERIOD_WIDTH (PW)
  ) dut (
    .core_clk       (core_clk),
    .core_resetn    (core_resetn),
    .sync_in        (sync_in),
    .sysref_in      (sysref_in),
    .clear_stats    (clear_stats),
    .expected_period(expected_period),
    .link_locked    (link_locked),
    .link_lost      (link_lost),
    .loss_count     (loss_count),
    .sysref_count   (sysref_count),
    .sysref_period  (sysref_period),
    .sysref_err     (sysref_err),
    .irq            (irq)
  );

  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc <= cyc + 1;

  task automatic model_clear();
    for (int k = 0; k < NL; k++) begin
      exp_loss[k] = 0;
      exp_lost[k] = 1'b0;
    end
    sr_cnt = 0; sr_period = 0; sr_err = 1'b0; sr_armed = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_stats = 1'b1;
    @(negedge core_clk);
    clear_stats = 1'b0;
    model_clear();
  endtask

  // Holds link k low for low_len cycles, then high until a relock must have happened.
  task automatic drop_link(input int k, input int low_len);
    sync_in[k] = 1'b0;
    repeat (low_len) @(negedge core_clk);
    sync_in[k] = 1'b1;
    if (low_len >= FC && exp_lock[k]) begin
      exp_loss[k] = (exp_loss[k] >= CNT_MAX) ? CNT_MAX : exp_loss[k] + 1;
      exp_lost[k] = 1'b1;
    end
    repeat (LOCK_LAT + 3) @(negedge core_clk);
    exp_lock[k] = 1'b1;
  endtask

  task automatic sysref_pulses(input int n, input int gap);
    int meas;
    for (int i = 0; i < n; i++) begin
      sysref_in = 1'b1;
      meas = cyc - sr_last;
      sr_last = cyc;
      if (sr_armed) begin
        sr_period = meas;
        if (expected_period != 0 && meas != int'(expected_period)) sr_err = 1'b1;
      end
      sr_armed = 1'b1;
      sr_cnt = (sr_cnt >= CNT_MAX) ? CNT_MAX : sr_cnt + 1;
      @(negedge core_clk);
      sysref_in = 1'b0;
      repeat (gap - 1) @(negedge core_clk);
    end
  endtask

  task automatic test_reset();
    core_resetn = 1'b0;
    repeat (3) @(negedge core_clk);
    n_tests++;
    if ({link_locked, link_lost, loss_count, sysref_count, sysref_period, sysref_err, irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {link_locked, link_lost, loss_count, sysref_count, sysref_period, sysref_err, irq});
    end
    core_resetn = 1'b1;
    model_clear();
    for (int k = 0; k < NL; k++) exp_lock[k] = 1'b0;
    repeat (2) @(negedge core_clk);
    n_tests++;
    if ({link_locked, irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 0", {link_locked, irq});
    end
  endtask

  task automatic test_qual_loss();
    int hi;
    hi = $urandom_range(20, 200);
    sync_in = 2'b11;
    repeat (hi) @(negedge core_clk);
    sync_in = 2'b00;
    repeat (FC + 10) @(negedge core_clk);
    n_tests++;
    if (link_locked !== 2'b00) begin
      n_fail++;
      $display("FAIL qual_locked: got %b expected 00 (high %0d cycles)", link_locked, hi);
    end
    n_tests++;
    if ({link_lost, loss_count, irq} !== '0) begin
      n_fail++;
      $display("FAIL qual_no_loss: got %h expected 0", {link_lost, loss_count, irq});
    end
  endtask

  task automatic test_lock_timing();
    sync_in = 2'b11;
    repeat (LOCK_LAT - 1) @(negedge core_clk);
    n_tests++;
    if (link_locked !== 2'b00) begin
      n_fail++;
      $display("FAIL lock_early: got %b expected 00 at edge %0d", link_locked, LOCK_LAT - 1);
    end
    @(negedge core_clk);
    n_tests++;
    if (link_locked !== 2'b11) begin
      n_fail++;
      $display("FAIL lock_time: got %b expected 11 at edge %0d", link_locked, LOCK_LAT);
    end
    n_tests++;
    if ({link_lost, loss_count, irq} !== '0) begin
      n_fail++;
      $display("FAIL lock_no_loss: got %h expected 0", {link_lost, loss_count, irq});
    end
    for (int k = 0; k < NL; k++) exp_lock[k] = 1'b1;
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 5; i++) begin
      int k, w;
      k = (i == 0) ? 1 : $urandom_range(0, NL - 1);
      w = (i == 0) ? FC - 1 : $urandom_range(1, FC - 1);
      sync_in[k] = 1'b0;
      repeat (w) @(negedge core_clk);
      sync_in[k] = 1'b1;
      repeat (6) @(negedge core_clk);
    end
    n_tests++;
    if (link_locked !== 2'b11) begin
      n_fail++;
      $display("FAIL glitch_locked: got %b expected 11", link_locked);
    end
    n_tests++;
    if ({link_lost, loss_count} !== '0) begin
      n_fail++;
      $display("FAIL glitch_loss: got %h expected 0", {link_lost, loss_count});
    end
  endtask

  task automatic test_link_loss();
    for (int i = 0; i < 3; i++) drop_link(0, $urandom_range(FC, 20));
    for (int k = 0; k < NL; k++) begin
      n_tests++;
      if (loss_count[k*CW +: CW] !== CW'(exp_loss[k])) begin
        n_fail++;
        $display("FAIL loss_count%0d: got %0d expected %0d", k, loss_count[k*CW +: CW], exp_loss[k]);
      end
    end
    n_tests++;
    if (link_lost !== {exp_lost[1], exp_lost[0]} || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_flags: got lost=%b irq=%b expected lost=%b irq=1",
               link_lost, irq, {exp_lost[1], exp_lost[0]});
    end
    pulse_clear();
    n_tests++;
    if ({link_lost, loss_count} !== '0) begin
      n_fail++;
      $display("FAIL loss_clear: got %h expected 0", {link_lost, loss_count});
    end
    @(negedge core_clk);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_irq_clear: got %b expected 0", irq);
    end
  endtask

  task automatic check_sysref(input string name);
    n_tests++;
    if (sysref_count !== CW'(sr_cnt) || sysref_period !== PW'(sr_period) || sysref_err !== sr_err) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d per=%0d err=%b expected cnt=%0d per=%0d err=%b",
               name, sysref_count, sysref_period, sysref_err, sr_cnt, sr_period, sr_err);
    end
  endtask

  task automatic test_sysref();
    int g;
    pulse_clear();
    expected_period = 16'd64;
    sysref_pulses(4, 64);
    check_sysref("sysref_64");
    sysref_pulses(2, 65);
    check_sysref("sysref_65");
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL sysref_irq: got %b expected 1", irq);
    end
    pulse_clear();
    expected_period = '0;
    g = $urandom_range(30, 90);
    sysref_pulses(3, g);
    check_sysref("sysref_disabled");
    pulse_clear();
    g = $urandom_range(20, 100);
    expected_period = PW'(g);
    sysref_pulses(3, g);
    check_sysref("sysref_match_rand");
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL sysref_irq_quiet: got %b expected 0", irq);
    end
    // Edge reaches the counters on the third clock after the rise; clear lands on that clock.
    sysref_in = 1'b1;
    sr_last = cyc;
    @(negedge core_clk);
    sysref_in = 1'b0;
    @(negedge core_clk);
    clear_stats = 1'b1;
    @(negedge core_clk);
    clear_stats = 1'b0;
    model_clear();
    sr_cnt = 1; sr_armed = 1'b1;
    repeat (5) @(negedge core_clk);
    check_sysref("sysref_clear_coincident");
    sysref_pulses(1, 10);
    check_sysref("sysref_after_coincident");
    pulse_clear();
    expected_period = '0;
    sysref_pulses(CNT_MAX + 2, 8);
    check_sysref("sysref_saturate");
  endtask

  task automatic test_saturation();
    pulse_clear();
    for (int i = 0; i < CNT_MAX + 2; i++) drop_link(0, $urandom_range(FC, 12));
    n_tests++;
    if (loss_count[CW-1:0] !== CW'(exp_loss[0])) begin
      n_fail++;
      $display("FAIL loss_saturate: got %0d expected %0d", loss_count[CW-1:0], exp_loss[0]);
    end
    // The loss event lands 2+FC clocks after the drop; clear is driven on that same clock.
    sync_in[0] = 1'b0;
    repeat (1 + FC) @(negedge core_clk);
    clear_stats = 1'b1;
    @(negedge core_clk);
    clear_stats = 1'b0;
    model_clear();
    exp_loss[0] = 1; exp_lost[0] = 1'b1;
    repeat (3) @(negedge core_clk);
    n_tests++;
    if (loss_count[CW-1:0] !== CW'(exp_loss[0]) || link_lost[0] !== exp_lost[0]) begin
      n_fail++;
      $display("FAIL loss_clear_coincident: got cnt=%0d lost=%b expected cnt=%0d lost=%b",
               loss_count[CW-1:0], link_lost[0], exp_loss[0], exp_lost[0]);
    end
    sync_in[0] = 1'b1;
    repeat (LOCK_LAT + 3) @(negedge core_clk);
  endtask

  task automatic test_reset_mid();
    n_tests++;
    if (link_locked !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_pre_locked: got %b expected 11", link_locked);
    end
    #2 core_resetn = 1'b0;
    #1;
    n_tests++;
    if ({link_locked, link_lost, loss_count, sysref_count, sysref_period, sysref_err, irq} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {link_locked, link_lost, loss_count, sysref_count, sysref_period, sysref_err, irq});
    end
    @(negedge core_clk);
    core_resetn = 1'b1;
    model_clear();
    repeat (LOCK_LAT + 3) @(negedge core_clk);
    n_tests++;
    if (link_locked !== 2'b11 || {link_lost, loss_count, irq} !== '0) begin
      n_fail++;
      $display("FAIL mid_relock: got locked=%b lost=%b cnt=%h irq=%b expected locked=11 rest 0",
               link_locked, link_lost, loss_count, irq);
    end
  endtask

  initial begin
    test_reset();
    test_qual_loss();
    test_lock_timing();
    test_glitch();
    test_link_loss();
    test_sysref();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
